axi_burst_ram_subordinate: RTL and testbench
============================================

// Module: axi_burst_ram_subordinate
// PURPOSE
// - AXI4 full subordinate backed by on-chip RAM; the responder end of a DMA-style AXI4 manager's read/write data port.
// - Lets co-simulation benches close the DMA data path in RTL without routing every beat through the Renode bus bridge.
// - Independent read and write engines share one 1W/1R storage array.
// PARAMETERS
// - DataWidth          32      data bus width in bits; power of 2, >= 32
// - AddressWidth       32      AXI address width
// - TransactionIdWidth 4       width of awid/bid/arid/rid
// - MemWords           1024    RAM depth in DataWidth words; power of 2
// - BaseAddress        32'h0   byte address of word 0; aligned to MemWords*DataWidth/8
// PORTS
// - clk      in  1    clock; all logic on posedge
// - reset    in  1    asynchronous, active-high reset
// - awid/awaddr/awlen/awsize/awburst  in  ID/AW/8/3/2  write address; awlock/awcache/awprot accepted and ignored
// - awvalid in 1 / awready out 1      write address handshake
// - wdata/wstrb/wlast  in  DW/DW/8/1  write data
// - wvalid in 1 / wready out 1        write data handshake
// - bid/bresp  out  ID/2              write response; bvalid out 1, bready in 1
// - arid/araddr/arlen/arsize/arburst  in  ID/AW/8/3/2  read address; arlock/arcache/arprot ignored
// - arvalid in 1 / arready out 1      read address handshake
// - rid/rdata/rresp/rlast  out  ID/DW/2/1  read data; rvalid out 1, rready in 1
// BEHAVIOUR
// - Reset: awready=wready=arready=0, bvalid=rvalid=rlast=0, bid/rid/bresp/rresp/rdata=0; both FSMs idle. RAM contents not cleared.
// - Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE:
//   - W_IDLE: awready=1. On AW handshake, latch id, addr, len, size and burst; go W_DATA.
//   - W_DATA: wready=1. Exactly awlen+1 beats are consumed. Per accepted beat, RAM bytes enabled by wstrb are written at the current word.
//   - W_DATA -> W_RESP after the beat with count==awlen. No AW accept while not in W_IDLE.
//   - W_RESP: bvalid=1 with latched bid; hold until bready. Return to W_IDLE the cycle after the B handshake.
// - Read FSM R_IDLE->R_ADDR->R_DATA->R_IDLE:
//   - R_IDLE: arready=1. On AR handshake, latch fields; go R_ADDR and issue the RAM read.
//   - R_ADDR: one-cycle RAM latency. First rvalid is 2 cycles after the AR handshake.
//   - R_DATA: rvalid=1; rdata, rresp, rlast and rid stay stable until rready.
//   - On each R handshake, the next beat is presented the following cycle, so sustained throughput is 1 beat per 2 cycles.
//   - rlast=1 only on beat arlen. Return to R_IDLE after the last handshake.
// - Address generation, per beat:
//   - FIXED (00): address constant.
//   - INCR (01): addr += 1<<size. The first beat of an unaligned start uses its own aligned word.
//   - WRAP (10): len must be 1/3/7/15. Boundary = (len+1)<<size; the address wraps to the aligned container base.
//   - RESERVED (11): no RAM access.
// - Responses:
//   - OKAY=00, SLVERR=10, DECERR=11.
//   - DECERR if any beat address falls outside [BaseAddress, BaseAddress+MemWords*DW/8). That beat is not written; read returns 0.
//   - SLVERR for RESERVED burst, size > log2(DW/8), or an illegal WRAP len. All beats are still completed; no RAM writes; reads return 0.
//   - Write wlast mismatch (early wlast, or missing at final beat): data is written normally; bresp=SLVERR; beat count stays governed by awlen.
//   - bresp is the highest-severity error seen across the burst; rresp is per beat.
// - Simultaneous read and write to the same word in one cycle: the read returns the old data.
// - Reset asserted mid-burst: both FSMs abort to idle immediately and all valids drop. Partially written beats remain in RAM.
// - INCR bursts crossing 4 KB are not checked and are simply followed.
// STRUCTURE
// - Shared package axi_pkg: burst_t enum (FIXED/INCR/WRAP/RSVD), resp_t constants, and a function computing the burst error class.
// - Sub-module axi_burst_addr_gen: combinational next address from addr/size/len/burst, plus a wrap mask.
//   - Instantiated twice, once per engine.
// - RAM: one reg array with a byte-enable write port and a registered read port.
// TESTING
// - INCR write id=3, awaddr=0x100, len=3, size=2, data 0x11..0x44 -> bid=3, bresp=00. Then read the same range -> rdata 0x11,0x22,0x33,0x44; rlast on beat 4 only; rid=3.
// - Write 0xAABBCCDD to 0x200 with wstrb=0101, over prior contents 0 -> readback 0x00BB00DD.
// - WRAP read len=3, size=2, araddr=0x108 -> word order 0x108, 0x10C, 0x100, 0x104; rresp=00 on every beat.
// - Read at BaseAddress+MemWords*4 with len=1 -> two beats, rresp=11, rdata=0. Write to the same address -> bresp=11, RAM unchanged.
// - Write len=3 with wlast on beat 2 -> 4 beats accepted, bresp=10. Also: arburst=11 -> rresp=10 on all beats.
// - Hold rready=0 for 5 cycles mid-burst -> rdata/rlast stable.
// - Assert reset during beat 2 of 4 -> all valids 0 next edge; the following transaction completes OKAY.

Source files
------------

// File: rtl/axi_pkg.sv
`default_nettype none
// axi_pkg -- burst/response encodings, engine state types and error helpers
// shared by the AXI4 burst RAM subordinate. Rev 1.0
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rstate_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [1:0] burst_err_class(input burst_t burst, input logic [2:0] size,
                                                 input logic [7:0] len, input logic [2:0] max_size);
    logic bad_wrap;
    bad_wrap = (burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    if (burst == BURST_RSVD || size > max_size || bad_wrap) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // Response encodings are ordered by severity, so a numeric max merges them.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// axi_burst_addr_gen -- combinational next-beat address for FIXED/INCR/WRAP
// bursts, plus the wrap container mask. Rev 1.0
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int AddressWidth = 32
) (
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [2:0]              size_i,
  input  logic [7:0]              len_i,
  input  burst_t                  burst_i,
  output logic [AddressWidth-1:0] next_addr_o,
  output logic [AddressWidth-1:0] wrap_mask_o
);

  logic [AddressWidth-1:0] w_incr;
  logic [AddressWidth-1:0] w_aligned_next;

  always_comb begin
    w_incr         = AddressWidth'(1) << size_i;
    w_aligned_next = (addr_i & ~(w_incr - AddressWidth'(1))) + w_incr;
    wrap_mask_o    = ((AddressWidth'(len_i) + AddressWidth'(1)) << size_i) - AddressWidth'(1);
    next_addr_o    = addr_i;
    case (burst_i)
      BURST_INCR: next_addr_o = w_aligned_next;
      BURST_WRAP: next_addr_o = (addr_i & ~wrap_mask_o) | (w_aligned_next & wrap_mask_o);
      default:    next_addr_o = addr_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_burst_ram_subordinate.sv
`default_nettype none
// axi_burst_ram_subordinate -- AXI4 subordinate over a 1W/1R byte-enable RAM
// with independent write and read burst engines. Rev 1.0
module axi_burst_ram_subordinate
  import axi_pkg::*;
#(
  parameter int                      DataWidth          = 32,
  parameter int                      AddressWidth       = 32,
  parameter int                      TransactionIdWidth = 4,
  parameter int                      MemWords           = 1024,
  parameter logic [AddressWidth-1:0] BaseAddress        = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [TransactionIdWidth-1:0] awid,
  input  logic [AddressWidth-1:0]       awaddr,
  input  logic [7:0]                    awlen,
  input  logic [2:0]                    awsize,
  input  logic [1:0]                    awburst,
  input  logic                          awlock,
  input  logic [3:0]                    awcache,
  input  logic [2:0]                    awprot,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [DataWidth-1:0]          wdata,
  input  logic [DataWidth/8-1:0]        wstrb,
  input  logic                          wlast,
  input  logic                          wvalid,
  output logic                          wready,
  output logic [TransactionIdWidth-1:0] bid,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  input  logic [TransactionIdWidth-1:0] arid,
  input  logic [AddressWidth-1:0]       araddr,
  input  logic [7:0]                    arlen,
  input  logic [2:0]                    arsize,
  input  logic [1:0]                    arburst,
  input  logic                          arlock,
  input  logic [3:0]                    arcache,
  input  logic [2:0]                    arprot,
  input  logic                          arvalid,
  output logic                          arready,
  output logic [TransactionIdWidth-1:0] rid,
  output logic [DataWidth-1:0]          rdata,
  output logic [1:0]                    rresp,
  output logic                          rlast,
  output logic                          rvalid,
  input  logic                          rready
);

  localparam int BYTES = DataWidth / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDXW  = $clog2(MemWords);
  localparam logic [2:0]            MAX_SIZE = 3'(OFFS);
  localparam logic [AddressWidth:0] LO_ADDR  = {1'b0, BaseAddress};
  localparam logic [AddressWidth:0] HI_ADDR  = LO_ADDR + (AddressWidth+1)'(MemWords * BYTES);

  function automatic logic [1:0] decode_resp(input logic [AddressWidth-1:0] a);
    return ({1'b0, a} >= LO_ADDR && {1'b0, a} < HI_ADDR) ? RESP_OKAY : RESP_DECERR;
  endfunction

  logic [DataWidth-1:0] mem_q [MemWords];
  logic [DataWidth-1:0] ram_rd_q;

  wstate_t                       wstate_q, wstate_d;
  logic [TransactionIdWidth-1:0] wid_q, wid_d;
  logic [AddressWidth-1:0]       waddr_q, waddr_d, w_wnext, w_wmask;
  logic [7:0]                    wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]                    wsize_q, wsize_d;
  burst_t                        wburst_q, wburst_d;
  logic [1:0]                    wresp_q, wresp_d;
  logic [1:0]                    w_wberr, w_wdec, w_wsev;
  logic                          w_wlast_err, w_mem_we;
  logic [IDXW-1:0]               w_widx;

  rstate_t                       rstate_q, rstate_d;
  logic [TransactionIdWidth-1:0] rid_q, rid_d;
  logic [AddressWidth-1:0]       raddr_q, raddr_d, w_rnext, w_rmask;
  logic [7:0]                    rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]                    rsize_q, rsize_d;
  burst_t                        rburst_q, rburst_d;
  logic [1:0]                    rresp_q, rresp_d, w_rsev;
  logic                          rlast_q, rlast_d, rzero_q, rzero_d;
  logic [IDXW-1:0]               w_ridx;

  logic w_unused;
  assign w_unused = ^{awlock, awcache, awprot, arlock, arcache, arprot, w_wmask, w_rmask};

  axi_burst_addr_gen #(.AddressWidth(AddressWidth)) u_waddr_gen (
    .addr_i(waddr_q), .size_i(wsize_q), .len_i(wlen_q), .burst_i(wburst_q),
    .next_addr_o(w_wnext), .wrap_mask_o(w_wmask)
  );

  axi_burst_addr_gen #(.AddressWidth(AddressWidth)) u_raddr_gen (
    .addr_i(raddr_q), .size_i(rsize_q), .len_i(rlen_q), .burst_i(rburst_q),
    .next_addr_o(w_rnext), .wrap_mask_o(w_rmask)
  );

  // A beat only touches RAM when the burst is legal and its address decodes.
  assign w_wberr     = burst_err_class(wburst_q, wsize_q, wlen_q, MAX_SIZE);
  assign w_wdec      = decode_resp(waddr_q);
  assign w_wlast_err = (wlast != (wcnt_q == wlen_q));
  assign w_wsev      = resp_max(resp_max(w_wberr, w_wdec), w_wlast_err ? RESP_SLVERR : RESP_OKAY);
  assign w_mem_we    = (wstate_q == W_DATA) && wvalid && (w_wberr == RESP_OKAY) && (w_wdec == RESP_OKAY);
  assign w_widx      = IDXW'((waddr_q - BaseAddress) >> OFFS);
  assign w_rsev      = resp_max(burst_err_class(rburst_q, rsize_q, rlen_q, MAX_SIZE), decode_resp(raddr_q));
  assign w_ridx      = IDXW'((raddr_q - BaseAddress) >> OFFS);

  always_comb begin
    wstate_d = wstate_q;
    wid_d    = wid_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wsize_d  = wsize_q;
    wburst_d = wburst_q;
    wcnt_d   = wcnt_q;
    wresp_d  = wresp_q;
    awready  = (wstate_q == W_IDLE) && !reset;
    wready   = (wstate_q == W_DATA);
    bvalid   = (wstate_q == W_RESP);
    bid      = wid_q;
    bresp    = wresp_q;
    case (wstate_q)
      W_IDLE: if (awvalid) begin
        wid_d    = awid;
        waddr_d  = awaddr;
        wlen_d   = awlen;
        wsize_d  = awsize;
        wburst_d = burst_t'(awburst);
        wcnt_d   = '0;
        wresp_d  = RESP_OKAY;
        wstate_d = W_DATA;
      end
      W_DATA: if (wvalid) begin
        wresp_d = resp_max(wresp_q, w_wsev);
        waddr_d = w_wnext;
        wcnt_d  = wcnt_q + 8'd1;
        if (wcnt_q == wlen_q) wstate_d = W_RESP;
      end
      W_RESP: if (bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rcnt_d   = rcnt_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    rzero_d  = rzero_q;
    arready  = (rstate_q == R_IDLE) && !reset;
    rvalid   = (rstate_q == R_DATA);
    rid      = rid_q;
    rresp    = rresp_q;
    rlast    = rlast_q;
    rdata    = rzero_q ? '0 : ram_rd_q;
    case (rstate_q)
      R_IDLE: if (arvalid) begin
        rid_d    = arid;
        raddr_d  = araddr;
        rlen_d   = arlen;
        rsize_d  = arsize;
        rburst_d = burst_t'(arburst);
        rcnt_d   = '0;
        rstate_d = R_ADDR;
      end
      R_ADDR: begin
        rresp_d  = w_rsev;
        rzero_d  = (w_rsev != RESP_OKAY);
        rlast_d  = (rcnt_q == rlen_q);
        rstate_d = R_DATA;
      end
      R_DATA: if (rready) begin
        rlast_d = 1'b0;
        if (rlast_q) begin
          rstate_d = R_IDLE;
        end else begin
          raddr_d  = w_rnext;
          rcnt_d   = rcnt_q + 8'd1;
          rstate_d = R_ADDR;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate_q <= W_IDLE;
      wid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= BURST_FIXED;
      wcnt_q   <= '0;
      wresp_q  <= RESP_OKAY;
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= BURST_FIXED;
      rcnt_q   <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
      rzero_q  <= 1'b1;
    end else begin
      wstate_q <= wstate_d;
      wid_q    <= wid_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wsize_q  <= wsize_d;
      wburst_q <= wburst_d;
      wcnt_q   <= wcnt_d;
      wresp_q  <= wresp_d;
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rsize_q  <= rsize_d;
      rburst_q <= rburst_d;
      rcnt_q   <= rcnt_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
      rzero_q  <= rzero_d;
    end
  end

  // Storage is not reset; a same-cycle read of a written word sees the old value.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) mem_q[w_widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstate_q == R_ADDR) ram_rd_q <= mem_q[w_ridx];
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_ram_subordinate.sv
`default_nettype none
// tb_axi_burst_ram_subordinate -- directed and randomized bursts checked
// against a byte-array memory model. Rev 1.0
module tb_axi_burst_ram_subordinate;

  localparam int BOUND = 64;
  localparam int MEMB  = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  awcache, arcache, wstrb;
  logic        awlock, arlock, awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready, arvalid, arready, rlast, rvalid, rready;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]  mref  [MEMB];
  logic [31:0] wbeat [256];
  logic [3:0]  sbeat [256];

  axi_burst_ram_subordinate dut (
    .clk(clk), .reset(reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Beat address from the burst rules, computed directly from the beat number.
  function automatic logic [31:0] ref_addr(input logic [31:0] start, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst, input int i);
    longint nb, al, bound, lo;
    nb = longint'(1) << size;
    al = (longint'(start) / nb) * nb;
    case (burst)
      2'b01: return (i == 0) ? start : 32'(al + i * nb);
      2'b10: begin
        bound = (longint'(len) + 1) * nb;
        lo    = (al / bound) * bound;
        return 32'(lo + ((al - lo + i * nb) % bound));
      end
      default: return start;
    endcase
  endfunction

  function automatic logic [1:0] ref_sev(input logic [1:0] burst, input logic [2:0] size,
                                         input logic [7:0] len, input logic [31:0] a);
    logic [1:0] e, d;
    e = (burst == 2'b11 || size > 3'd2 || (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})))
        ? 2'b10 : 2'b00;
    d = (a < MEMB) ? 2'b00 : 2'b11;
    return (e > d) ? e : d;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int w;
    w = int'(a & 32'hFFFF_FFFC);
    return {mref[w+3], mref[w+2], mref[w+1], mref[w]};
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int last_at);
    int t, w;
    logic [31:0] a;
    logic [1:0]  sev, exp_resp;
    exp_resp = 2'b00;
    @(negedge clk);
    awvalid = 1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    t = 0;
    while (!awready && t < BOUND) begin @(negedge clk); t++; end
    chk("aw_handshake", awready, 1);
    @(posedge clk); @(negedge clk);
    awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1; wdata = wbeat[i]; wstrb = sbeat[i]; wlast = (i == last_at);
      t = 0;
      while (!wready && t < BOUND) begin @(negedge clk); t++; end
      a   = ref_addr(addr, len, size, burst, i);
      sev = ref_sev(burst, size, len, a);
      if (sev == 2'b00) begin
        w = int'(a & 32'hFFFF_FFFC);
        for (int b = 0; b < 4; b++) if (sbeat[i][b]) mref[w+b] = wbeat[i][b*8 +: 8];
      end
      if ((i == last_at) != (i == int'(len)) && sev < 2'b10) sev = 2'b10;
      if (sev > exp_resp) exp_resp = sev;
      @(posedge clk); @(negedge clk);
    end
    wvalid = 0; wlast = 0; bready = 1;
    t = 0;
    while (!bvalid && t < BOUND) begin @(negedge clk); t++; end
    chk("bvalid", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, exp_resp);
    @(posedge clk); @(negedge clk);
    bready = 0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int max_delay,
                          input int hold_beat);
    int t;
    logic [31:0] a, ed;
    logic [1:0]  es;
    @(negedge clk);
    arvalid = 1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    t = 0;
    while (!arready && t < BOUND) begin @(negedge clk); t++; end
    chk("ar_handshake", arready, 1);
    @(posedge clk); @(negedge clk);
    arvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!rvalid && t < BOUND) begin @(negedge clk); t++; end
      chk("r_latency", t, 1);
      a  = ref_addr(addr, len, size, burst, i);
      es = ref_sev(burst, size, len, a);
      ed = (es == 2'b00) ? ref_word(a) : 32'h0;
      chk("rdata", rdata, ed);
      chk("rresp", rresp, es);
      chk("rlast", rlast, (i == int'(len)));
      chk("rid", rid, id);
      if (i == hold_beat) begin
        repeat (5) begin
          @(negedge clk);
          chk("hold_rvalid", rvalid, 1);
          chk("hold_rdata", rdata, ed);
          chk("hold_rlast", rlast, (i == int'(len)));
        end
      end else begin
        repeat ($urandom_range(0, max_delay)) @(negedge clk);
      end
      rready = 1;
      @(posedge clk); @(negedge clk);
      rready = 0;
    end
  endtask

  initial begin
    int t;
    logic [1:0] rb;
    logic [2:0] rs;
    logic [7:0] rl;
    reset = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awlock = 0; awcache = 0; awprot = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arlock = 0; arcache = 0; arprot = 0;
    wdata = 0; wstrb = 0; wlast = 0;
    for (int i = 0; i < MEMB; i++) mref[i] = 8'h00;
    #2 reset = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_ids_resps", {bid, rid, bresp, rresp}, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk) reset = 0;

    // Zero the whole array so the model starts from known contents.
    for (int i = 0; i < 256; i++) begin wbeat[i] = 0; sbeat[i] = 4'hF; end
    for (int k = 0; k < 4; k++) axi_write(4'd0, 32'(k * 1024), 8'd255, 3'd2, 2'b01, 255);

    for (int i = 0; i < 4; i++) wbeat[i] = 32'h11 * (i + 1);
    axi_write(4'd3, 32'h100, 8'd3, 3'd2, 2'b01, 3);
    axi_read(4'd3, 32'h100, 8'd3, 3'd2, 2'b01, 0, -1);

    wbeat[0] = 32'hAABBCCDD; sbeat[0] = 4'b0101;
    axi_write(4'd1, 32'h200, 8'd0, 3'd2, 2'b01, 0);
    axi_read(4'd1, 32'h200, 8'd0, 3'd2, 2'b01, 0, -1);
    chk("strb_word", ref_word(32'h200), 32'h00BB00DD);
    sbeat[0] = 4'hF;

    axi_read(4'd5, 32'h108, 8'd3, 3'd2, 2'b10, 1, -1);

    axi_read(4'd6, 32'h1000, 8'd1, 3'd2, 2'b01, 0, -1);
    wbeat[0] = 32'hDEADBEEF; wbeat[1] = 32'hCAFEF00D;
    axi_write(4'd6, 32'h1000, 8'd1, 3'd2, 2'b01, 1);
    axi_read(4'd6, 32'h0, 8'd1, 3'd2, 2'b01, 0, -1);

    for (int i = 0; i < 4; i++) wbeat[i] = 32'h5000 + i;
    axi_write(4'd7, 32'h300, 8'd3, 3'd2, 2'b01, 2);
    axi_read(4'd7, 32'h300, 8'd3, 3'd2, 2'b01, 0, -1);
    axi_read(4'd8, 32'h100, 8'd3, 3'd2, 2'b11, 0, -1);

    axi_read(4'd9, 32'h100, 8'd3, 3'd2, 2'b01, 0, 1);

    // Reset while the second of four read beats is being presented.
    @(negedge clk);
    arvalid = 1; arid = 4'd2; araddr = 32'h100; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
    t = 0;
    while (!arready && t < BOUND) begin @(negedge clk); t++; end
    @(posedge clk); @(negedge clk);
    arvalid = 0;
    t = 0;
    while (!rvalid && t < BOUND) begin @(negedge clk); t++; end
    rready = 1;
    @(posedge clk); @(negedge clk);
    rready = 0;
    t = 0;
    while (!rvalid && t < BOUND) begin @(negedge clk); t++; end
    chk("pre_reset_rvalid", rvalid, 1);
    reset = 1;
    @(posedge clk); #1;
    chk("mid_reset_rvalid", rvalid, 0);
    chk("mid_reset_bvalid", bvalid, 0);
    chk("mid_reset_rlast", rlast, 0);
    chk("mid_reset_readies", {awready, wready, arready}, 0);
    @(negedge clk) reset = 0;
    for (int i = 0; i < 4; i++) wbeat[i] = $urandom;
    axi_write(4'd4, 32'h40, 8'd3, 3'd2, 2'b01, 3);
    axi_read(4'd4, 32'h40, 8'd3, 3'd2, 2'b01, 2, -1);

    for (int n = 0; n < 40; n++) begin
      rb = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rs = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if (rb == 2'b10) rl = ($urandom_range(0, 7) == 0) ? 8'd2 : 8'((1 << $urandom_range(1, 4)) - 1);
      else rl = 8'($urandom_range(0, 7));
      for (int i = 0; i <= int'(rl); i++) begin wbeat[i] = $urandom; sbeat[i] = 4'($urandom); end
      t = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'(rl);
      araddr = 32'($urandom_range(0, MEMB + 63));
      axi_write(4'($urandom), araddr, rl, rs, rb, t);
      axi_read(4'($urandom), araddr, rl, rs, rb, 3, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
